// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Time-multiplexed scan of an 8-digit, active-low 7-segment
//            display. Each digit slot opens with an all-anodes-off blanking
//            interval, disabled digits are skipped, and new display data is
//            taken only at frame boundaries so a value is never shown torn.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            enable     - scanning runs while high
//            digit_en   - per-digit enable mask (bit i -> anodos[i])
//            value      - eight hex nibbles, nibble i shown on digit i
//            dp         - decimal point request per digit, active-high
//            load       - strobe capturing value/dp into the pending register
//            segments   - {CA..CG}, active-low
//            dp_n       - decimal point, active-low
//            anodos     - anode drives, active-low
//            digit_idx  - index of the digit being scanned
//            frame_done - one-cycle pulse when a frame completes
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] digit_en,
  input  logic [31:0] value,
  input  logic [7:0] dp,
  input  logic       load,
  output logic [6:0] segments,
  output logic       dp_n,
  output logic [7:0] anodos,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] c_show_last  = CW'(SCAN_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  // Display data is packed as {value[31:0], dp[7:0]}.
  logic [39:0]     r_pending, r_active, w_active_nxt, w_frame_data;
  logic            w_frame_done_nxt;
  logic [3:0]      w_above, w_lowest;
  logic [31:0]     w_vals;
  logic [3:0]      w_nib;
  logic            w_dpbit;

  // Returns {found, index} of the lowest set bit of mask at position >= from.
  function automatic logic [3:0] first_set(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] res;
    res = 4'h0;
    for (int j = 7; j >= 0; j--) begin
      if (mask[j] && (j >= int'(from))) res = {1'b1, 3'(j)};
    end
    return res;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign w_above  = first_set(digit_en, {1'b0, r_idx} + 4'd1);
  assign w_lowest = first_set(digit_en, 4'd0);
  // A load coinciding with a frame start goes straight to the active copy.
  assign w_frame_data = load ? {value, dp} : r_pending;

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_active_nxt     = r_active;
    w_frame_done_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_lowest[3]) begin
            w_state_nxt  = BLANK;
            w_idx_nxt    = w_lowest[2:0];
            w_cnt_nxt    = '0;
            w_active_nxt = w_frame_data;
          end
        end
        BLANK: begin
          if (r_cnt == c_blank_last) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (r_cnt == c_show_last) begin
            // Index decision: digit_en is only looked at here.
            w_cnt_nxt = '0;
            if (w_above[3]) begin
              w_state_nxt = BLANK;
              w_idx_nxt   = w_above[2:0];
            end else if (w_lowest[3]) begin
              w_state_nxt      = BLANK;
              w_idx_nxt        = w_lowest[2:0];
              w_frame_done_nxt = 1'b1;
              w_active_nxt     = w_frame_data;
            end else begin
              w_state_nxt = IDLE;
              w_idx_nxt   = 3'd0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe; segments are already valid during blanking.
  assign w_vals  = w_active_nxt[39:8];
  assign w_nib   = w_vals[{w_idx_nxt, 2'b00} +: 4];
  assign w_dpbit = w_active_nxt[w_idx_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_active   <= '0;
      anodos     <= 8'hFF;
      segments   <= 7'h7F;
      dp_n       <= 1'b1;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_active   <= w_active_nxt;
      if (load) r_pending <= {value, dp};
      anodos     <= (w_state_nxt == SHOW) ? ~(8'h01 << w_idx_nxt) : 8'hFF;
      segments   <= (w_state_nxt == IDLE) ? 7'h7F : hex7(w_nib);
      dp_n       <= (w_state_nxt == IDLE) ? 1'b1 : ~w_dpbit;
      digit_idx  <= w_idx_nxt;
      frame_done <= w_frame_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Directed self-checking bench for display_scan_ctrl with
//            SCAN_DIV=8, BLANK_CYCLES=2 (2 blank + 6 lit cycles per slot).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  digit_en;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        load;
  logic [6:0]  segments;
  logic        dp_n;
  logic [7:0]  anodos;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Hand-written active-low {CA..CG} patterns for hex 0..F.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clk = ~clk;

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_en(digit_en),
    .value(value), .dp(dp), .load(load), .segments(segments), .dp_n(dp_n),
    .anodos(anodos), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  // Expected anodes for digit d at phase p of its slot.
  function automatic logic [7:0] exp_an(input int d, input int p);
    logic [7:0] one;
    one = 8'h01;
    return (p < BC) ? 8'hFF : ~(one << d);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; digit_en = 8'h00; value = '0; dp = 8'h00; load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({anodos, segments, dp_n, digit_idx, frame_done} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=ff seg=1111111 dpn=1 idx=0 fd=0",
               anodos, segments, dp_n, digit_idx, frame_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({anodos, segments, dp_n, digit_idx, frame_done} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_idle got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=ff seg=1111111 dpn=1 idx=0 fd=0",
               anodos, segments, dp_n, digit_idx, frame_done);
    end
  endtask

  // Drop enable: next cycle must be IDLE with blanked outputs and idx 0.
  task automatic test_enable_off(input string nm);
    enable = 1'b0; load = 1'b0;
    @(negedge clk);
    checks++;
    if ({anodos, segments, dp_n, digit_idx, frame_done} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=ff seg=1111111 dpn=1 idx=0 fd=0",
               nm, anodos, segments, dp_n, digit_idx, frame_done);
    end
  endtask

  task automatic test_full_scan();
    logic [7:0] dpv, ea; logic [6:0] es; logic ed, ef; int f, d, p;
    dpv = 8'h81;
    enable = 1'b1; digit_en = 8'hFF; value = 32'h76543210; dp = dpv; load = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      load = 1'b0;
      f = (k - 1) % 64; d = f / 8; p = f % 8;
      ea = exp_an(d, p); es = seg_tab[d]; ed = ~dpv[d]; ef = (k == 65);
      checks++;
      if ({anodos, segments, dp_n, digit_idx, frame_done} !== {ea, es, ed, 3'(d), ef}) begin
        errors++;
        $display("FAIL full_scan k=%0d got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=%h seg=%b dpn=%b idx=%0d fd=%b",
                 k, anodos, segments, dp_n, digit_idx, frame_done, ea, es, ed, d, ef);
      end
    end
    test_enable_off("full_scan_disable");
  endtask

  task automatic test_mask();
    logic [7:0] dpv, ea; logic [6:0] es; logic ed, ef; int f, d, p;
    int seq [3] = '{0, 5, 7};
    dpv = 8'h81;  // pending still holds 76543210 / dp 81
    enable = 1'b1; digit_en = 8'b1010_0001; load = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      f = (k - 1) % 24; d = seq[f / 8]; p = f % 8;
      ea = exp_an(d, p); es = seg_tab[d]; ed = ~dpv[d]; ef = (k == 25);
      checks++;
      if ({anodos, segments, dp_n, digit_idx, frame_done} !== {ea, es, ed, 3'(d), ef}) begin
        errors++;
        $display("FAIL mask_skip k=%0d got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=%h seg=%b dpn=%b idx=%0d fd=%b",
                 k, anodos, segments, dp_n, digit_idx, frame_done, ea, es, ed, d, ef);
      end
    end
    test_enable_off("mask_disable");
  endtask

  task automatic test_load_midframe();
    logic [7:0] ea; logic [6:0] es; logic ed, ef; int f, d, p;
    enable = 1'b1; digit_en = 8'hFF; value = 32'h76543210; dp = 8'h00; load = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      load = (k + 1 == 28);  // lands in the lit part of digit 3's slot
      if (load) begin value = 32'hFFFF_FFFF; dp = 8'hFF; end
      f = (k - 1) % 64; d = f / 8; p = f % 8;
      ea = exp_an(d, p);
      es = (k <= 64) ? seg_tab[d] : seg_tab[15];
      ed = (k <= 64) ? 1'b1 : 1'b0;
      ef = (k == 65);
      checks++;
      if ({anodos, segments, dp_n, digit_idx, frame_done} !== {ea, es, ed, 3'(d), ef}) begin
        errors++;
        $display("FAIL load_midframe k=%0d got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=%h seg=%b dpn=%b idx=%0d fd=%b",
                 k, anodos, segments, dp_n, digit_idx, frame_done, ea, es, ed, d, ef);
      end
    end
    test_enable_off("load_midframe_disable");
  endtask

  task automatic test_load_at_frame_start();
    logic [7:0] ea; logic [6:0] es; logic ed, ef; int f, d, p;
    enable = 1'b1; digit_en = 8'h03; value = 32'h0; dp = 8'h00; load = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      load = (k + 1 == 17);  // same edge as the wrap to the next frame
      if (load) value = 32'h1111_1111;
      f = (k - 1) % 16; d = f / 8; p = f % 8;
      ea = exp_an(d, p);
      es = (k <= 16) ? seg_tab[0] : seg_tab[1];
      ed = 1'b1;
      ef = (k == 17) || (k == 33);
      checks++;
      if ({anodos, segments, dp_n, digit_idx, frame_done} !== {ea, es, ed, 3'(d), ef}) begin
        errors++;
        $display("FAIL load_bypass k=%0d got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=%h seg=%b dpn=%b idx=%0d fd=%b",
                 k, anodos, segments, dp_n, digit_idx, frame_done, ea, es, ed, d, ef);
      end
    end
    test_enable_off("load_bypass_disable");
  endtask

  task automatic test_mask_off();
    logic [7:0] ea; logic [6:0] es; logic ed, ef; logic [2:0] ei; int f, d, p;
    enable = 1'b1; digit_en = 8'hFF; value = 32'h76543210; dp = 8'h00; load = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k + 1 >= 21)      digit_en = 8'b0010_0100;
      else if (k + 1 >= 12) digit_en = 8'h00;  // cleared mid digit-1 slot
      else                  digit_en = 8'hFF;
      if (k <= 16) begin
        d = (k - 1) / 8; p = (k - 1) % 8;
        ea = exp_an(d, p); es = seg_tab[d]; ed = 1'b1; ei = 3'(d); ef = 1'b0;
      end else if (k <= 20) begin
        ea = 8'hFF; es = 7'h7F; ed = 1'b1; ei = 3'd0; ef = 1'b0;
      end else begin
        f = k - 21; d = ((f / 8) % 2 == 0) ? 2 : 5; p = f % 8;
        ea = exp_an(d, p); es = seg_tab[d]; ed = 1'b1; ei = 3'(d); ef = (k == 37);
      end
      checks++;
      if ({anodos, segments, dp_n, digit_idx, frame_done} !== {ea, es, ed, ei, ef}) begin
        errors++;
        $display("FAIL mask_off_restart k=%0d got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=%h seg=%b dpn=%b idx=%0d fd=%b",
                 k, anodos, segments, dp_n, digit_idx, frame_done, ea, es, ed, ei, ef);
      end
    end
    test_enable_off("mask_off_disable");
  endtask

  task automatic test_async_reset();
    logic [7:0] ea; logic [6:0] es; int d, p;
    enable = 1'b1; digit_en = 8'hFF; value = 32'h76543210; dp = 8'h00; load = 1'b1;
    repeat (5) begin
      @(negedge clk);
      load = 1'b0;
    end
    checks++;
    if (anodos !== 8'hFE) begin
      errors++;
      $display("FAIL areset_pre_show got an=%h want an=fe", anodos);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({anodos, segments, dp_n, digit_idx, frame_done} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL areset_immediate got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=ff seg=1111111 dpn=1 idx=0 fd=0",
               anodos, segments, dp_n, digit_idx, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Active and pending were cleared, so every digit shows 0.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      d = (k - 1) / 8; p = (k - 1) % 8;
      ea = exp_an(d, p); es = seg_tab[0];
      checks++;
      if ({anodos, segments, dp_n, digit_idx, frame_done} !== {ea, es, 1'b1, 3'(d), 1'b0}) begin
        errors++;
        $display("FAIL areset_restart k=%0d got an=%h seg=%b dpn=%b idx=%0d fd=%b want an=%h seg=%b dpn=1 idx=%0d fd=0",
                 k, anodos, segments, dp_n, digit_idx, frame_done, ea, es, d);
      end
    end
    test_enable_off("areset_disable");
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_mask();
    test_load_midframe();
    test_load_at_frame_start();
    test_mask_off();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
